regfile_param: RTL and testbench

Parametrised general-purpose register file for the pipelined core's instruction-decode stage. It provides two combinational read ports and one synchronous write port, with configurable data width and depth and an optional hardwired-zero register 0. A sequential clear engine zeroes the whole array after reset or on request, so the array can be built without per-entry reset. Optional write-to-read bypass forwards same-cycle write-back data to decode.

---
 rtl/regfile_param.sv | 121 ++++++++++++
 tb/tb_regfile_param.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_param.sv
// Parametrised register file: two combinational read ports, one write port, sequential clear engine.
// Optional same-cycle write-to-read bypass enabled by defining REGFILE_BYPASS_EN.
module regfile_param #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              reg_write_i,
    input  logic [ADDR_W-1:0] write_reg_i,
    input  logic [DATA_W-1:0] write_data_i,
    input  logic [ADDR_W-1:0] read_reg1_i,
    input  logic [ADDR_W-1:0] read_reg2_i,
    output logic [DATA_W-1:0] read_data1_o,
    output logic [DATA_W-1:0] read_data2_o,
    input  logic              clr_start_i,
    output logic              clr_busy_o,
    output logic              wr_drop_o
);

    localparam int DEPTH = 2 ** ADDR_W;

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
    logic              wr_drop_q, wr_drop_d;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              wr_accept;
    logic              write_is_zero;

    assign write_is_zero = (ZERO_REG != 0) && (write_reg_i == '0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= CLEAR;
            clr_ptr_q <= '0;
            wr_drop_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            wr_drop_q <= wr_drop_d;
        end
    end

    // The clear engine and the external write share the single array write port.
    always_comb begin
        state_d   = state_q;
        clr_ptr_d = clr_ptr_q;
        wr_drop_d = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = write_reg_i;
        mem_wdata = write_data_i;
        wr_accept = 1'b0;
        case (state_q)
            CLEAR: begin
                mem_we    = 1'b1;
                mem_addr  = clr_ptr_q;
                mem_wdata = '0;
                clr_ptr_d = clr_ptr_q + ADDR_W'(1);
                wr_drop_d = reg_write_i;
                if (clr_ptr_q == {ADDR_W{1'b1}}) begin
                    state_d = IDLE;
                end
            end
            IDLE: begin
                if (clr_start_i) begin
                    state_d   = CLEAR;
                    clr_ptr_d = '0;
                    wr_drop_d = reg_write_i;
                end else if (reg_write_i && !write_is_zero) begin
                    wr_accept = 1'b1;
                    mem_we    = 1'b1;
                end
            end
            default: begin
                state_d   = CLEAR;
                clr_ptr_d = '0;
            end
        endcase
    end

    // No reset on the array: the clear engine is what initialises it.
    always_ff @(posedge clk_i) begin
        if (mem_we) begin
            mem_q[mem_addr] <= mem_wdata;
        end
    end

    function automatic logic [DATA_W-1:0] read_port(input logic [ADDR_W-1:0] addr);
        logic [DATA_W-1:0] rd;
        rd = '0;
        if (state_q == IDLE && !((ZERO_REG != 0) && (addr == '0))) begin
            rd = mem_q[addr];
`ifdef REGFILE_BYPASS_EN
            if (wr_accept && (write_reg_i == addr)) begin
                rd = write_data_i;
            end
`endif
        end
        return rd;
    endfunction

    always_comb begin
        read_data1_o = read_port(read_reg1_i);
        read_data2_o = read_port(read_reg2_i);
    end

    assign clr_busy_o = (state_q == CLEAR);
    assign wr_drop_o  = wr_drop_q;

endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench for regfile_param: directed steps plus a randomized phase against a
// behavioural model (a register array and a count of clear cycles still to run).
module tb_regfile_param;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 32;

    logic              clk;
    logic              rst;
    logic              regWrite;
    logic [ADDR_W-1:0] writeReg;
    logic [DATA_W-1:0] writeData;
    logic [ADDR_W-1:0] readReg1;
    logic [ADDR_W-1:0] readReg2;
    logic [DATA_W-1:0] readData1;
    logic [DATA_W-1:0] readData2;
    logic              clrStart;
    logic              clrBusy;
    logic              wrDrop;

    logic [DATA_W-1:0] model [DEPTH];
    int                clearRemaining;
    logic              expDrop;
    int                checks;
    int                errors;

    regfile_param #(
        .DATA_W  (DATA_W),
        .ADDR_W  (ADDR_W),
        .ZERO_REG(1)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .reg_write_i (regWrite),
        .write_reg_i (writeReg),
        .write_data_i(writeData),
        .read_reg1_i (readReg1),
        .read_reg2_i (readReg2),
        .read_data1_o(readData1),
        .read_data2_o(readData2),
        .clr_start_i (clrStart),
        .clr_busy_o  (clrBusy),
        .wr_drop_o   (wrDrop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] expRead(input logic [ADDR_W-1:0] addr);
        if (rst || clearRemaining > 0) return '0;
        if (addr == 0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (regWrite && !clrStart && writeReg == addr) return writeData;
`endif
        return model[addr];
    endfunction

    task automatic modelReset();
        clearRemaining = DEPTH;
        expDrop        = 1'b0;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
    endtask

    // Advances the model by one rising edge using the inputs held across that edge.
    task automatic updateModel();
        if (rst) begin
            modelReset();
        end else if (clearRemaining > 0) begin
            expDrop = regWrite;
            clearRemaining--;
        end else begin
            expDrop = clrStart && regWrite;
            if (clrStart) begin
                modelReset();
                expDrop = regWrite;
            end else if (regWrite && writeReg != 0) begin
                model[writeReg] = writeData;
            end
        end
    endtask

    task automatic applyStimulus(input logic we, input logic [ADDR_W-1:0] wa,
                                 input logic [DATA_W-1:0] wd, input logic [ADDR_W-1:0] r1,
                                 input logic [ADDR_W-1:0] r2, input logic cs);
        regWrite  = we;
        writeReg  = wa;
        writeData = wd;
        readReg1  = r1;
        readReg2  = r2;
        clrStart  = cs;
    endtask

    task automatic checkOutput(input string tag);
        logic [DATA_W-1:0] e1;
        logic [DATA_W-1:0] e2;
        logic              eBusy;
        e1    = expRead(readReg1);
        e2    = expRead(readReg2);
        eBusy = (rst || clearRemaining > 0);
        checks += 4;
        assert (readData1 === e1) else begin
            errors++;
            $error("[TB] FAIL %s read_data1 observed=%h expected=%h", tag, readData1, e1);
        end
        assert (readData2 === e2) else begin
            errors++;
            $error("[TB] FAIL %s read_data2 observed=%h expected=%h", tag, readData2, e2);
        end
        assert (clrBusy === eBusy) else begin
            errors++;
            $error("[TB] FAIL %s clr_busy observed=%b expected=%b", tag, clrBusy, eBusy);
        end
        assert (wrDrop === expDrop) else begin
            errors++;
            $error("[TB] FAIL %s wr_drop observed=%b expected=%b", tag, wrDrop, expDrop);
        end
    endtask

    // Check mid-cycle, then cross one rising edge and update the model.
    task automatic doCycle(input string tag);
        @(negedge clk);
        checkOutput(tag);
        @(posedge clk);
        #1;
        updateModel();
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b1;
        applyStimulus(1'b0, '0, '0, '0, '0, 1'b0);
        modelReset();
        @(posedge clk);
        #1;
        doCycle("reset_held");
        doCycle("reset_held2");

        // Release reset; attempt a write early in the clear so it is dropped.
        rst = 1'b0;
        applyStimulus(1'b1, 5'd5, 32'h0000_0077, 5'd5, 5'd9, 1'b0);
        doCycle("initclr_wr");
        for (int i = 1; i < DEPTH + 2; i++) begin
            applyStimulus(1'b0, '0, '0, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1'b0);
            doCycle("initclr");
        end
        for (int i = 0; i < DEPTH; i++) begin
            applyStimulus(1'b0, '0, '0, 5'(i), 5'(DEPTH - 1 - i), 1'b0);
            doCycle("all_zero");
        end

        // Basic write/read and hardwired zero.
        applyStimulus(1'b1, 5'd5, 32'hDEAD_BEEF, 5'd1, 5'd2, 1'b0);
        doCycle("wr_r5");
        applyStimulus(1'b0, '0, '0, 5'd5, 5'd5, 1'b0);
        doCycle("rd_r5");
        applyStimulus(1'b1, 5'd0, 32'h0000_1234, 5'd0, 5'd5, 1'b0);
        doCycle("wr_r0");
        applyStimulus(1'b0, '0, '0, 5'd0, 5'd0, 1'b0);
        doCycle("rd_r0");

        // Same-cycle write/read of r7 on port 1; port 2 watches r5.
        applyStimulus(1'b1, 5'd7, 32'hA5A5_A5A5, 5'd7, 5'd5, 1'b0);
        doCycle("bypass_r7");
        applyStimulus(1'b0, '0, '0, 5'd7, 5'd7, 1'b0);
        doCycle("after_r7");

        // Write during clear is dropped and r3 stays zero.
        applyStimulus(1'b1, 5'd3, 32'h0000_00AA, 5'd3, 5'd7, 1'b0);
        doCycle("wr_r3");
        applyStimulus(1'b0, '0, '0, 5'd3, 5'd7, 1'b1);
        doCycle("clr_start");
        applyStimulus(1'b1, 5'd3, 32'h0000_0055, 5'd3, 5'd7, 1'b0);
        doCycle("clr_wr_r3");
        for (int i = 0; i < DEPTH + 1; i++) begin
            applyStimulus(1'b0, '0, '0, 5'd3, 5'd7, 1'b0);
            doCycle("clr_run");
        end

        // Reset mid-clear restarts a full clear.
        applyStimulus(1'b1, 5'd9, 32'h0000_0099, 5'd9, 5'd3, 1'b0);
        doCycle("wr_r9");
        applyStimulus(1'b0, '0, '0, 5'd9, 5'd3, 1'b1);
        doCycle("clr2_start");
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, '0, '0, 5'd9, 5'd3, 1'b0);
            doCycle("clr2_run");
        end
        applyStimulus(1'b1, 5'd4, 32'h0000_0044, 5'd9, 5'd4, 1'b0);
        rst = 1'b1;
        modelReset();
        #1;
        checkOutput("async_rst");
        doCycle("rst_mid");
        rst = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            applyStimulus(1'b0, '0, '0, 5'd9, 5'd4, 1'b0);
            doCycle("clr3_run");
        end

        // clr_start during clear is ignored.
        applyStimulus(1'b1, 5'd12, 32'h0C0C_0C0C, 5'd12, 5'd1, 1'b0);
        doCycle("wr_r12");
        applyStimulus(1'b0, '0, '0, 5'd12, 5'd1, 1'b1);
        doCycle("clr4_start");
        for (int i = 0; i < DEPTH + 2; i++) begin
            applyStimulus(1'b0, '0, '0, 5'd12, 5'd1, (i == 4));
            doCycle("clr4_run");
        end

        // Randomized traffic with occasional clear requests.
        for (int i = 0; i < 400; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom(),
                          5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                          ($urandom_range(0, 59) == 0));
            if ($urandom_range(0, 3) == 0) begin
                readReg1 = writeReg;
            end
            doCycle("random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
